dmem_result_monitor: RTL and testbench

//   Snoops the data-memory write port between PipeCPU and DataMemory inside PipeSystem.

---
 rtl/dmem_result_monitor.sv | 115 +++++++++++
 tb/tb_dmem_result_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_result_monitor.sv
// dmem_result_monitor
//   Passive observer on the data-memory write port between the CPU and data memory.
//   After an arm pulse it counts RUN cycles and stores, captures the data of the first
//   store to the watched word and raises a sticky done flag. If no hit arrives within
//   TIMEOUT_CYCLES, it raises a sticky timeout flag instead. It never drives the port.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   arm          in   pulse: clear counters and start watching (ignored while running)
//   memWrite     in   data-memory write enable
//   memAddr      in   data-memory byte address (bits [1:0] ignored for the match)
//   memWriteData in   data-memory write data
//   running      out  high while watching
//   done         out  sticky: watched word written
//   timeout      out  sticky: no hit within TIMEOUT_CYCLES
//   result       out  data of the capturing store
//   cycles       out  RUN cycles elapsed, including the capture cycle
//   storeCount   out  stores seen while running (saturating)
module dmem_result_monitor #(
  parameter logic [31:0] WATCH_ADDR     = 32'h0000_001C,
  parameter int unsigned TIMEOUT_CYCLES = 30000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned WCNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              memWrite,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       memWriteData,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       result,
  output logic [CNT_W-1:0]  cycles,
  output logic [WCNT_W-1:0] storeCount
);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StTimeout} state_e;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CycOne      = CNT_W'(1);
  localparam logic [WCNT_W-1:0] StoreOne   = WCNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [WCNT_W-1:0]   count_q, count_d;
  logic [31:0]         result_q, result_d;
  logic                running_q, done_q, timeout_q;
  logic                hit;

  // Word-granular match: byte offset within the word is ignored.
  assign hit = memWrite && (memAddr[31:2] == WATCH_ADDR[31:2]);

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    count_d  = count_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (arm) begin
          state_d  = StRun;
          cycles_d = '0;
          count_d  = '0;
          result_d = '0;
        end
      end
      StRun: begin
        cycles_d = cycles_q + CycOne;
        if (memWrite && (count_q != '1)) begin
          count_d = count_q + StoreOne;
        end
        // A hit on the last allowed cycle still wins over the timeout.
        if (hit) begin
          result_d = memWriteData;
          state_d  = StDone;
        end else if (cycles_q == TimeoutLast) begin
          state_d = StTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cycles_q  <= '0;
      count_q   <= '0;
      result_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      count_q   <= count_d;
      result_q  <= result_d;
      // Flags registered from next state so they line up with state_q.
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
      timeout_q <= (state_d == StTimeout);
    end
  end

  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign result     = result_q;
  assign cycles     = cycles_q;
  assign storeCount = count_q;

endmodule

// File: tb/tb_dmem_result_monitor.sv
module tb_dmem_result_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        running, done, timeout;
  logic [31:0] result;
  logic [31:0] cycles;
  logic [2:0]  storeCount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dmem_result_monitor #(
    .WATCH_ADDR    (32'h0000_001C),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (32),
    .WCNT_W        (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .arm         (arm),
    .memWrite    (memWrite),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .running     (running),
    .done        (done),
    .timeout     (timeout),
    .result      (result),
    .cycles      (cycles),
    .storeCount  (storeCount)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memWrite = 1'b1;
    memAddr = a;
    memWriteData = d;
    tick();
    memWrite = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic r, input logic dn, input logic to,
                           input logic [31:0] res, input logic [31:0] cyc,
                           input logic [2:0] sc);
    check({tag, ".running"}, 64'(running), 64'(r));
    check({tag, ".done"}, 64'(done), 64'(dn));
    check({tag, ".timeout"}, 64'(timeout), 64'(to));
    check({tag, ".result"}, 64'(result), 64'(res));
    check({tag, ".cycles"}, 64'(cycles), 64'(cyc));
    check({tag, ".storeCount"}, 64'(storeCount), 64'(sc));
  endtask

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    memWrite = 1'b0;
    memAddr = '0;
    memWriteData = '0;
    tick();
    tick();
    reset = 1'b0;
    check_all("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Store in IDLE is neither counted nor captured.
    store(32'h1C, 32'd55);
    check_all("idle_store", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    // 1: hit on RUN cycle 5.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_all("t1_armed", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (4) tick();
    check("t1_cyc4", 64'(cycles), 64'd4);
    store(32'h1C, 32'd89);
    check_all("t1_done", 1'b0, 1'b1, 1'b0, 32'd89, 32'd5, 3'd1);

    // 5: store to watched word while DONE leaves everything frozen.
    store(32'h1C, 32'd5);
    check_all("t5_frozen", 1'b0, 1'b1, 1'b0, 32'd89, 32'd5, 3'd1);

    // 2: arm held two cycles starts one run; 3 other stores, then hit at 0x1E.
    arm = 1'b1;
    tick();
    check_all("t2_armed", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    arm = 1'b0;
    check("t2_arm_ignored", 64'(cycles), 64'd1);
    repeat (3) store(32'h0C, 32'hDEAD);
    check("t2_count3", 64'(storeCount), 64'd3);
    store(32'h1E, 32'd7);
    check_all("t2_done", 1'b0, 1'b1, 1'b0, 32'd7, 32'd5, 3'd4);

    // 3: timeout after 8 RUN cycles; stores every cycle also saturate storeCount at 7.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (7) store(32'h20, 32'h1234);
    check_all("t3_pre", 1'b1, 1'b0, 1'b0, 32'd0, 32'd7, 3'd7);
    store(32'h20, 32'h1234);
    check_all("t3_timeout", 1'b0, 1'b0, 1'b1, 32'd0, 32'd8, 3'd7);
    store(32'h1C, 32'd99);
    check_all("t3_frozen", 1'b0, 1'b0, 1'b1, 32'd0, 32'd8, 3'd7);

    // 4: hit on RUN cycle 8 beats the timeout; byte offset 3 still matches.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_all("t4_armed", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (7) tick();
    store(32'h1F, 32'hAB);
    check_all("t4_done", 1'b0, 1'b1, 1'b0, 32'hAB, 32'd8, 3'd1);

    // Byte offset 1 also hits.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    store(32'h1D, 32'h3C);
    check_all("t4b_done", 1'b0, 1'b1, 1'b0, 32'h3C, 32'd1, 3'd1);

    // 6: reset during RUN cycle 3 (with a hit present) aborts with no capture.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    check("t6_cyc2", 64'(cycles), 64'd2);
    reset = 1'b1;
    store(32'h1C, 32'd77);
    reset = 1'b0;
    check_all("t6_reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    store(32'h1C, 32'd78);
    check_all("t6_noarm", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
